addmul_seq_ctrl: RTL and testbench



---
 rtl/addmul_pkg.sv | 20 ++
 rtl/pp_mul_32x8.sv | 26 ++
 rtl/rca_32.sv | 24 ++
 rtl/addmul_seq_ctrl.sv | 154 +++++++++++++++
 tb/tb_addmul_seq_ctrl.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/addmul_pkg.sv
// Shared constants and state encoding for the add/multiply sequencing controller.
package addmul_pkg;

    localparam int unsigned OPND_W = 32;
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned PP_W   = OPND_W + BYTE_W;
    localparam int unsigned ACC_W  = 2 * OPND_W;
    localparam int unsigned K_W    = 2;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_MUL = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADD  = 2'd1,
        ST_MUL  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/pp_mul_32x8.sv
// Combinational 32x8 partial-product unit; k selects which byte of b multiplies a.
// Ports: a (32), b (32), k (2) byte select; pp_c (40) = a * b[8k+7:8k].
module pp_mul_32x8
    import addmul_pkg::*;
(
    input  logic [OPND_W-1:0] a,
    input  logic [OPND_W-1:0] b,
    input  logic [K_W-1:0]    k,
    output logic [PP_W-1:0]   pp_c
);

    logic [BYTE_W-1:0] b_byte;

    always_comb begin
        b_byte = b[7:0];
        unique case (k)
            2'd0: b_byte = b[7:0];
            2'd1: b_byte = b[15:8];
            2'd2: b_byte = b[23:16];
            2'd3: b_byte = b[31:24];
            default: b_byte = b[7:0];
        endcase
        pp_c = PP_W'(a) * PP_W'(b_byte);
    end

endmodule

// File: rtl/rca_32.sv
// 32-bit ripple-carry adder.
// Ports: a, b (32), cin; sum_c (32), cout_c.
module rca_32
    import addmul_pkg::*;
(
    input  logic [OPND_W-1:0] a,
    input  logic [OPND_W-1:0] b,
    input  logic              cin,
    output logic [OPND_W-1:0] sum_c,
    output logic              cout_c
);

    logic [OPND_W:0] carry;

    assign carry[0] = cin;

    for (genvar i = 0; i < OPND_W; i++) begin : g_fa
        assign sum_c[i]     = a[i] ^ b[i] ^ carry[i];
        assign carry[i + 1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end

    assign cout_c = carry[OPND_W];

endmodule

// File: rtl/addmul_seq_ctrl.sv
// Sequencing controller for the shared 32-bit adder / 32x8 multiplier datapath.
// ADD takes one cycle; MUL shift-accumulates four byte partial products into a
// 64-bit product, optionally stopping once the remaining bytes of B are zero.
// Ports: clk, nrst (async active-low); in_valid/in_ready request handshake with
// op (0 ADD, 1 MUL), a, b; out_valid/out_ready result handshake with result (64);
// busy high whenever not idle.
module addmul_seq_ctrl
    import addmul_pkg::*;
#(
    parameter bit          EARLY_EXIT = 1'b1,
    parameter int unsigned ACC_W      = addmul_pkg::ACC_W
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              op,
    input  logic [OPND_W-1:0] a,
    input  logic [OPND_W-1:0] b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  result,
    output logic              busy
);

    state_t             state_q, state_d;
    logic [OPND_W-1:0]  a_q, a_d;
    logic [OPND_W-1:0]  b_q, b_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [K_W-1:0]     k_q, k_d;
    logic [ACC_W-1:0]   result_q, result_d;
    logic               out_valid_q, out_valid_d;
    logic               in_ready_q, in_ready_d;
    logic               busy_q, busy_d;

    logic [PP_W-1:0]    pp;
    logic [OPND_W-1:0]  sum;
    logic               cout;
    logic [ACC_W-1:0]   acc_sum;
    logic               hi_zero;
    logic               mul_last;

    // Datapath sees only the latched operands.
    pp_mul_32x8 u_pp (
        .a    (a_q),
        .b    (b_q),
        .k    (k_q),
        .pp_c (pp)
    );

    rca_32 u_add (
        .a      (a_q),
        .b      (b_q),
        .cin    (1'b0),
        .sum_c  (sum),
        .cout_c (cout)
    );

    // Shift-accumulate of the current byte's partial product; cannot overflow 64 bits.
    always_comb begin
        acc_sum = acc_q + (ACC_W'(pp) << {k_q, 3'b000});
    end

    // True when every byte of B above the current one is zero.
    always_comb begin
        hi_zero = 1'b1;
        unique case (k_q)
            2'd0: hi_zero = (b_q[31:8]  == 24'd0);
            2'd1: hi_zero = (b_q[31:16] == 16'd0);
            2'd2: hi_zero = (b_q[31:24] == 8'd0);
            2'd3: hi_zero = 1'b1;
            default: hi_zero = 1'b1;
        endcase
        mul_last = (k_q == 2'd3) || (EARLY_EXIT && hi_zero);
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        acc_d       = acc_q;
        k_d         = k_q;
        result_d    = result_q;
        out_valid_d = out_valid_q;

        unique case (state_q)
            ST_IDLE: begin
                if (in_valid && in_ready_q) begin
                    a_d     = a;
                    b_d     = b;
                    acc_d   = '0;
                    k_d     = '0;
                    state_d = (op == OP_MUL) ? ST_MUL : ST_ADD;
                end
            end
            ST_ADD: begin
                result_d    = ACC_W'({cout, sum});
                out_valid_d = 1'b1;
                state_d     = ST_DONE;
            end
            ST_MUL: begin
                acc_d = acc_sum;
                if (mul_last) begin
                    result_d    = acc_sum;
                    out_valid_d = 1'b1;
                    state_d     = ST_DONE;
                end else begin
                    k_d = k_q + 2'd1;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        in_ready_d = (state_d == ST_IDLE);
        busy_d     = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q     <= ST_IDLE;
            a_q         <= '0;
            b_q         <= '0;
            acc_q       <= '0;
            k_q         <= '0;
            result_q    <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            acc_q       <= acc_d;
            k_q         <= k_d;
            result_q    <= result_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_addmul_seq_ctrl.sv
// Bench for addmul_seq_ctrl: one instance with early exit, one without, driven
// by the same stimulus and checked against a transaction-level model.
module tb_addmul_seq_ctrl;

    logic        clk = 1'b0;
    logic        nrst;
    logic        in_valid;
    logic        op;
    logic [31:0] a;
    logic [31:0] b;
    logic        out_ready;

    logic [1:0]  in_ready_w;
    logic [1:0]  out_valid_w;
    logic [1:0]  busy_w;
    logic [63:0] result_w [2];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    addmul_seq_ctrl #(.EARLY_EXIT(1'b1)) dut_ee (
        .clk       (clk),
        .nrst      (nrst),
        .in_valid  (in_valid),
        .in_ready  (in_ready_w[0]),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid_w[0]),
        .out_ready (out_ready),
        .result    (result_w[0]),
        .busy      (busy_w[0])
    );

    addmul_seq_ctrl #(.EARLY_EXIT(1'b0)) dut_ne (
        .clk       (clk),
        .nrst      (nrst),
        .in_valid  (in_valid),
        .in_ready  (in_ready_w[1]),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid_w[1]),
        .out_ready (out_ready),
        .result    (result_w[1]),
        .busy      (busy_w[1])
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level model ----------------
    bit          m_idle [2];
    int          m_cnt  [2];
    bit          m_ov   [2];
    logic [63:0] m_res  [2];
    logic [63:0] m_pend [2];

    // Cycles from accept to result for MUL, from how many bytes of B matter.
    function automatic int mul_lat(input logic [31:0] bb, input bit ee);
        if (!ee)                 return 4;
        if (bb[31:8]  == 24'd0)  return 1;
        if (bb[31:16] == 16'd0)  return 2;
        if (bb[31:24] == 8'd0)   return 3;
        return 4;
    endfunction

    always @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            for (int i = 0; i < 2; i++) begin
                m_idle[i] <= 1'b1;
                m_cnt[i]  <= 0;
                m_ov[i]   <= 1'b0;
                m_res[i]  <= 64'd0;
                m_pend[i] <= 64'd0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (m_idle[i]) begin
                    if (in_valid) begin
                        m_idle[i] <= 1'b0;
                        m_pend[i] <= op ? (64'(a) * 64'(b)) : (64'(a) + 64'(b));
                        m_cnt[i]  <= op ? mul_lat(b, i == 0) : 1;
                    end
                end else if (m_cnt[i] > 0) begin
                    m_cnt[i] <= m_cnt[i] - 1;
                    if (m_cnt[i] == 1) begin
                        m_ov[i]  <= 1'b1;
                        m_res[i] <= m_pend[i];
                    end
                end else if (m_ov[i] && out_ready) begin
                    m_ov[i]   <= 1'b0;
                    m_idle[i] <= 1'b1;
                end
            end
        end
    end

    // Per-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (nrst === 1'b1) begin
            for (int i = 0; i < 2; i++) begin
                chk($sformatf("out_valid[%0d]", i), 64'(out_valid_w[i]), 64'(m_ov[i]));
                chk($sformatf("in_ready[%0d]", i),  64'(in_ready_w[i]),  64'(m_idle[i]));
                chk($sformatf("busy[%0d]", i),      64'(busy_w[i]),      64'(!m_idle[i]));
                chk($sformatf("result[%0d]", i),    result_w[i],         m_res[i]);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic o, input logic [31:0] aa, input logic [31:0] bb,
                         output int c0);
        in_valid = 1'b1;
        op       = o;
        a        = aa;
        b        = bb;
        c0       = -1;
        for (int n = 0; n < 50; n++) begin
            if (in_ready_w == 2'b11) begin
                tick();
                c0       = cyc;
                in_valid = 1'b0;
                op       = ~o;
                a        = $urandom;
                b        = $urandom;
                return;
            end
            tick();
        end
        checks++;
        errors++;
        $display("FAIL issue_timeout actual=in_ready 0x%0h required=0x3", in_ready_w);
        in_valid = 1'b0;
    endtask

    task automatic wait_done(input int c0, output int lat0, output int lat1);
        lat0 = -1;
        lat1 = -1;
        for (int n = 0; n < 20; n++) begin
            if (out_valid_w[0] && lat0 < 0) lat0 = cyc - c0;
            if (out_valid_w[1] && lat1 < 0) lat1 = cyc - c0;
            if (lat0 >= 0 && lat1 >= 0) return;
            tick();
        end
        checks++;
        errors++;
        $display("FAIL done_timeout actual=out_valid 0x%0h required=0x3", out_valid_w);
    endtask

    task automatic take();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("in_ready_after_take", 64'(in_ready_w), 64'd3);
    endtask

    // Directed MUL/ADD transaction with literal expectations for both instances.
    task automatic run_op(input string name, input logic o, input logic [31:0] aa,
                          input logic [31:0] bb, input int lat_ee, input int lat_ne,
                          input logic [63:0] exp);
        int c0, l0, l1;
        issue(o, aa, bb, c0);
        chk({name, "_in_ready_low"}, 64'(in_ready_w), 64'd0);
        wait_done(c0, l0, l1);
        chk({name, "_lat_ee"}, 64'(l0), 64'(lat_ee));
        chk({name, "_lat_ne"}, 64'(l1), 64'(lat_ne));
        chk({name, "_res_ee"}, result_w[0], exp);
        chk({name, "_res_ne"}, result_w[1], exp);
        chk({name, "_model"},  m_res[0],    exp);
        take();
    endtask

    initial begin
        int c0, l0, l1;
        nrst      = 1'b0;
        in_valid  = 1'b0;
        op        = 1'b0;
        a         = 32'd0;
        b         = 32'd0;
        out_ready = 1'b0;
        repeat (2) tick();

        for (int i = 0; i < 2; i++) begin
            chk("rst_in_ready",  64'(in_ready_w[i]),  64'd1);
            chk("rst_out_valid", 64'(out_valid_w[i]), 64'd0);
            chk("rst_busy",      64'(busy_w[i]),      64'd0);
            chk("rst_result",    result_w[i],         64'd0);
        end
        nrst = 1'b1;
        tick();

        run_op("add_carry", 1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 1, 1, 64'h0000_0001_0000_0000);
        run_op("mul_max",   1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4, 4, 64'hFFFF_FFFE_0000_0001);
        run_op("mul_small", 1'b1, 32'd3,         32'd5,         1, 4, 64'd15);
        run_op("mul_byte2", 1'b1, 32'h1234_5678, 32'h0001_0000, 3, 4, 64'h0000_1234_5678_0000);
        run_op("mul_zero",  1'b1, 32'hDEAD_BEEF, 32'd0,         1, 4, 64'd0);
        run_op("mul_byte1", 1'b1, 32'h0000_0100, 32'h0000_0200, 2, 4, 64'h0000_0000_0002_0000);

        // Backpressure with a pending request that must wait for in_ready.
        issue(1'b1, 32'd7, 32'd9, c0);
        wait_done(c0, l0, l1);
        in_valid = 1'b1;
        op       = 1'b0;
        a        = 32'd100;
        b        = 32'd23;
        for (int n = 0; n < 5; n++) begin
            for (int i = 0; i < 2; i++) begin
                chk("bp_result",    result_w[i],         64'd63);
                chk("bp_out_valid", 64'(out_valid_w[i]), 64'd1);
                chk("bp_busy",      64'(busy_w[i]),      64'd1);
                chk("bp_in_ready",  64'(in_ready_w[i]),  64'd0);
            end
            tick();
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("bp_idle_in_ready",  64'(in_ready_w),  64'd3);
        chk("bp_idle_out_valid", 64'(out_valid_w), 64'd0);
        tick();
        c0       = cyc;
        in_valid = 1'b0;
        chk("bp_accept", 64'(in_ready_w), 64'd0);
        wait_done(c0, l0, l1);
        chk("bp_add_lat", 64'(l0), 64'd1);
        chk("bp_add_res", result_w[0], 64'd123);
        take();

        // Asynchronous abort in the middle of a MUL.
        issue(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, c0);
        tick();
        #2 nrst = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            chk("abort_out_valid", 64'(out_valid_w[i]), 64'd0);
            chk("abort_result",    result_w[i],         64'd0);
            chk("abort_in_ready",  64'(in_ready_w[i]),  64'd1);
            chk("abort_busy",      64'(busy_w[i]),      64'd0);
        end
        nrst = 1'b1;
        for (int n = 0; n < 6; n++) begin
            tick();
            chk("abort_no_stale", 64'(out_valid_w), 64'd0);
        end
        run_op("add_after_abort", 1'b0, 32'd2, 32'd2, 1, 1, 64'd4);

        repeat (3) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
